// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope generator: stage codes and envelope limits.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_e;

  localparam logic [15:0] ENV_MAX = 16'hFFFF;

endpackage

// File: rtl/env_tick.sv
// Free-running prescaler: tick is high for one clk cycle every TICK_DIV cycles.
module env_tick #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Wrap the counter after the last count of the period.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator: gate edges switch stages immediately, tick-paced steps
// move the 16-bit envelope through attack, decay, sustain and release.
module adsr_env
  import adsr_pkg::*;
#(
  parameter int TICK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gate,
  input  logic [15:0] attack_rate,
  input  logic [15:0] decay_rate,
  input  logic [15:0] sustain_level,
  input  logic [15:0] release_rate,
  output logic [15:0] env_out,
  output logic [2:0]  stage,
  output logic        busy
);

  logic               tick_s;
  logic               gate_q;
  logic               rise_s;
  logic               fall_s;
  logic               step_s;
  stage_e             stage_q;
  stage_e             stage_d;
  logic [15:0]        env_q;
  logic [15:0]        env_d;
  logic               busy_q;
  logic               busy_d;
  logic [16:0]        sum_s;
  logic signed [16:0] dec_s;
  logic signed [16:0] rel_s;
  logic signed [16:0] sus_s;

  env_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_s)
  );

  assign rise_s = gate & ~gate_q;
  assign fall_s = ~gate & gate_q;
  // A gate edge owns its cycle: the envelope never steps at the same time.
  assign step_s = tick_s & ~rise_s & ~fall_s;

  assign sum_s = {1'b0, env_q} + {1'b0, attack_rate};
  assign dec_s = $signed({1'b0, env_q}) - $signed({1'b0, decay_rate});
  assign rel_s = $signed({1'b0, env_q}) - $signed({1'b0, release_rate});
  assign sus_s = $signed({1'b0, sustain_level});

  // Next stage and envelope value.
  always_comb begin
    stage_d = stage_q;
    env_d   = env_q;
    case (stage_q)
      ST_IDLE: begin
        env_d = 16'h0000;
        if (rise_s) begin
          stage_d = ST_ATTACK;
        end else begin
          stage_d = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (fall_s) begin
          stage_d = ST_RELEASE;
        end else if (step_s) begin
          if (sum_s >= {1'b0, ENV_MAX}) begin
            env_d   = ENV_MAX;
            stage_d = ST_DECAY;
          end else begin
            env_d = sum_s[15:0];
          end
        end else begin
          env_d = env_q;
        end
      end
      ST_DECAY: begin
        if (fall_s) begin
          stage_d = ST_RELEASE;
        end else if (step_s) begin
          // Also catches entry at or below sustain: first tick lands on it.
          if (dec_s <= sus_s) begin
            env_d   = sustain_level;
            stage_d = ST_SUSTAIN;
          end else begin
            env_d = dec_s[15:0];
          end
        end else begin
          env_d = env_q;
        end
      end
      ST_SUSTAIN: begin
        if (fall_s) begin
          stage_d = ST_RELEASE;
        end else if (step_s) begin
          env_d = sustain_level;
        end else begin
          env_d = env_q;
        end
      end
      ST_RELEASE: begin
        if (rise_s) begin
          stage_d = ST_ATTACK;
        end else if (step_s) begin
          if (rel_s <= 17'sd0) begin
            env_d   = 16'h0000;
            stage_d = ST_IDLE;
          end else begin
            env_d = rel_s[15:0];
          end
        end else begin
          env_d = env_q;
        end
      end
      default: begin
        stage_d = ST_IDLE;
        env_d   = 16'h0000;
      end
    endcase
    busy_d = (stage_d != ST_IDLE);
  end

  // State, envelope and gate history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q  <= 1'b0;
      stage_q <= ST_IDLE;
      env_q   <= 16'h0000;
      busy_q  <= 1'b0;
    end else begin
      gate_q  <= gate;
      stage_q <= stage_d;
      env_q   <= env_d;
      busy_q  <= busy_d;
    end
  end

  assign env_out = env_q;
  assign stage   = stage_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adsr_env.sv
// Self-checking bench for adsr_env: an integer-arithmetic envelope model checked every
// cycle (TICK_DIV=1 instance) plus directed literal checks on both instances.
module tb_adsr_env;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] attack_rate = 16'h4000;
  logic [15:0] decay_rate = 16'h1000;
  logic [15:0] sustain_level = 16'h8000;
  logic [15:0] release_rate = 16'h3000;
  logic [15:0] env_out;
  logic [2:0]  stage;
  logic        busy;

  logic        rst50_n = 1'b0;
  logic        gate50 = 1'b0;
  logic [15:0] attack50 = 16'h0001;
  logic [15:0] decay50 = 16'h0001;
  logic [15:0] sustain50 = 16'h0000;
  logic [15:0] release50 = 16'h0001;
  logic [15:0] env50;
  logic [2:0]  stage50;
  logic        busy50;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int m_env = 0;
  int m_stage = 0;
  bit m_gq = 1'b0;
  int m_env_n;
  int m_stage_n;

  always #5 clk = ~clk;

  adsr_env #(.TICK_DIV(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_level(sustain_level),
    .release_rate (release_rate),
    .env_out      (env_out),
    .stage        (stage),
    .busy         (busy)
  );

  adsr_env #(.TICK_DIV(50)) dut50 (
    .clk          (clk),
    .rst_n        (rst50_n),
    .gate         (gate50),
    .attack_rate  (attack50),
    .decay_rate   (decay50),
    .sustain_level(sustain50),
    .release_rate (release50),
    .env_out      (env50),
    .stage        (stage50),
    .busy         (busy50)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Envelope behaviour for one tick (TICK_DIV=1 means every cycle is a tick).
  function automatic void model_next(input int e, input int s, input bit g, input bit gq,
                                     input int atk, input int dec, input int sus, input int rel,
                                     output int ne, output int ns);
    bit rise;
    bit fall;
    rise = g && !gq;
    fall = !g && gq;
    ne = e;
    ns = s;
    if (s == 0) begin
      ne = 0;
      if (rise) ns = 1;
    end else if (rise && s == 4) begin
      ns = 1;
    end else if (fall && s != 4) begin
      ns = 4;
    end else if (!(rise || fall)) begin
      case (s)
        1: begin
          ne = (e + atk >= 65535) ? 65535 : e + atk;
          if (ne == 65535) ns = 2;
        end
        2: begin
          ne = e - dec;
          if (ne <= sus) begin
            ne = sus;
            ns = 3;
          end
        end
        3: ne = sus;
        4: begin
          ne = e - rel;
          if (ne <= 0) begin
            ne = 0;
            ns = 0;
          end
        end
        default: ns = 0;
      endcase
    end
  endfunction

  always_comb begin
    m_env_n = 0;
    m_stage_n = 0;
    model_next(m_env, m_stage, gate, m_gq, int'(attack_rate), int'(decay_rate),
               int'(sustain_level), int'(release_rate), m_env_n, m_stage_n);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_env <= 0;
      m_stage <= 0;
      m_gq <= 1'b0;
    end else begin
      m_env <= m_env_n;
      m_stage <= m_stage_n;
      m_gq <= gate;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model env", int'(env_out), m_env);
      chk("model stage", int'(stage), m_stage);
      chk("model busy", int'(busy), (m_stage != 0) ? 1 : 0);
    end
  end

  task automatic exp1(input string name, input int e, input int s);
    @(posedge clk);
    #1;
    chk({name, " env"}, int'(env_out), e);
    chk({name, " stage"}, int'(stage), s);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset env", int'(env_out), 0);
    chk("reset stage", int'(stage), 0);
    chk("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    exp1("idle", 0, 0);

    gate = 1'b1;
    exp1("atk0", 16'h0000, 1);
    exp1("atk1", 16'h4000, 1);
    exp1("atk2", 16'h8000, 1);
    exp1("atk3", 16'hC000, 1);
    exp1("atk_sat", 16'hFFFF, 2);
    for (int i = 0; i < 7; i++) exp1("decay", 32'hEFFF - i * 32'h1000, 2);
    exp1("sus_entry", 16'h8000, 3);
    exp1("sus_hold", 16'h8000, 3);

    gate = 1'b0;
    exp1("rel_fall", 16'h8000, 4);
    exp1("rel1", 16'h5000, 4);
    exp1("rel2", 16'h2000, 4);
    exp1("rel_end", 16'h0000, 0);
    chk("idle busy", int'(busy), 0);

    gate = 1'b1;
    exp1("re_a0", 16'h0000, 1);
    exp1("re_a1", 16'h4000, 1);
    exp1("re_a2", 16'h8000, 1);
    gate = 1'b0;
    exp1("re_fall", 16'h8000, 4);
    exp1("re_rel", 16'h5000, 4);
    gate = 1'b1;
    exp1("retrig", 16'h5000, 1);
    exp1("retrig1", 16'h9000, 1);
    exp1("retrig2", 16'hD000, 1);
    exp1("retrig_sat", 16'hFFFF, 2);

    sustain_level = 16'hFFFF;
    exp1("sus_max", 16'hFFFF, 3);
    sustain_level = 16'h1000;
    exp1("sus_track", 16'h1000, 3);
    exp1("sus_track2", 16'h1000, 3);

    gate = 1'b0;
    exp1("rel_small", 16'h1000, 4);
    exp1("rel_clamp", 16'h0000, 0);
    gate = 1'b1;
    exp1("pulse_atk", 16'h0000, 1);
    gate = 1'b0;
    exp1("pulse_rel", 16'h0000, 4);
    exp1("pulse_idle", 16'h0000, 0);

    gate = 1'b1;
    exp1("frz_a0", 16'h0000, 1);
    exp1("frz_a1", 16'h4000, 1);
    attack_rate = 16'h0000;
    exp1("frz_hold1", 16'h4000, 1);
    exp1("frz_hold2", 16'h4000, 1);
    attack_rate = 16'h4000;
    exp1("frz_resume", 16'h8000, 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst env", int'(env_out), 0);
    chk("async rst stage", int'(stage), 0);
    chk("async rst busy", int'(busy), 0);
    rst_n = 1'b1;
    exp1("post_rst_rise", 16'h0000, 1);
    exp1("post_rst_a1", 16'h4000, 1);
    exp1("post_rst_a2", 16'h8000, 1);
    exp1("post_rst_a3", 16'hC000, 1);
    exp1("post_rst_sat", 16'hFFFF, 2);
    decay_rate = 16'h0000;
    exp1("dec_frz1", 16'hFFFF, 2);
    exp1("dec_frz2", 16'hFFFF, 2);
    release_rate = 16'h0000;
    gate = 1'b0;
    exp1("relz_fall", 16'hFFFF, 4);
    exp1("relz_hold", 16'hFFFF, 4);
    release_rate = 16'h8000;
    exp1("relz_step", 16'h7FFF, 4);
    exp1("relz_end", 16'h0000, 0);

    // Slow instance: first step lands on the 50th edge after reset release.
    gate50 = 1'b1;
    rst50_n = 1'b1;
    @(posedge clk);
    #1;
    chk("div50 rise stage", int'(stage50), 1);
    repeat (48) @(posedge clk);
    #1;
    chk("div50 pre tick env", int'(env50), 0);
    @(posedge clk);
    #1;
    chk("div50 tick1 env", int'(env50), 1);
    repeat (49) @(posedge clk);
    #1;
    chk("div50 hold env", int'(env50), 1);
    @(posedge clk);
    #1;
    chk("div50 tick2 env", int'(env50), 2);
    repeat (50) @(posedge clk);
    #1;
    chk("div50 tick3 env", int'(env50), 3);
    chk("div50 tick3 stage", int'(stage50), 1);
    #2;
    rst50_n = 1'b0;
    #1;
    chk("div50 async env", int'(env50), 0);
    chk("div50 async stage", int'(stage50), 0);
    chk("div50 async busy", int'(busy50), 0);
    rst50_n = 1'b1;
    @(posedge clk);
    #1;
    chk("div50 rearm stage", int'(stage50), 1);
    chk("div50 rearm env", int'(env50), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adsr_env.md
ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50, meaning clk cycles per envelope step (50 MHz / 50 = 1 MHz step rate); legal range 1..65535.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port gate  input  1  note-on level, synchronous to clk.
REQ-005 SHALL have port attack_rate  input  16  unsigned increment per step in ATTACK.
REQ-006 SHALL have port decay_rate  input  16  unsigned decrement per step in DECAY.
REQ-007 SHALL have port sustain_level  input  16  unsigned hold level.
REQ-008 SHALL have port release_rate  input  16  unsigned decrement per step in RELEASE.
REQ-009 SHALL have port env_out  output  16  registered envelope, drives the synth amp_in.
REQ-010 SHALL have port stage  output  3  registered state code.
REQ-011 SHALL have port busy  output  1  high whenever stage != IDLE.

Function
REQ-012 SHALL run a free-running tick counter 0..TICK_DIV-1; tick asserts for one cycle when the counter equals TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-013 SHALL register gate into gate_q each cycle; rise = gate & ~gate_q, fall = ~gate & gate_q.
REQ-014 SHALL implement states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5-7 unused and recover to IDLE on the next cycle.
REQ-015 SHALL move IDLE or RELEASE -> ATTACK on rise, independent of tick, keeping env_out unchanged (no click on retrigger).
REQ-016 SHALL move ATTACK, DECAY or SUSTAIN -> RELEASE on fall, independent of tick, keeping env_out unchanged.
REQ-017 SHALL give gate edges priority over tick-driven updates in the same cycle: no env step that cycle.
REQ-018 ATTACK on tick: env = min(env + attack_rate, 0xFFFF) using 17-bit sum; on reaching 0xFFFF, go to DECAY in the same update.
REQ-019 DECAY on tick: env = max(env - decay_rate, sustain_level) using 17-bit signed compare; on reaching sustain_level, go to SUSTAIN in the same update.
REQ-020 SHALL go DECAY -> SUSTAIN on the first tick if env <= sustain_level on entry, loading env = sustain_level.
REQ-021 SUSTAIN: env SHALL equal sustain_level each tick, tracking input changes at tick rate.
REQ-022 RELEASE on tick: env = max(env - release_rate, 0); on reaching 0, go to IDLE in the same update.
REQ-023 rate of 0 SHALL freeze env in that stage until a gate edge; no error flag.
REQ-024 latency: a gate edge at clk edge N (gate changes before N, sampled at N into gate_q) SHALL show in stage at edge N+1; env step visible one cycle after its tick.
REQ-025 IDLE SHALL hold env_out = 0.

Reset
REQ-026 rst_n low SHALL asynchronously force stage=IDLE, env_out=0, busy=0, gate_q=0, tick counter=0.
REQ-027 reset mid-envelope SHALL abort immediately; after release, gate held high SHALL produce a rise (gate_q=0) and start ATTACK from 0.

Structure
REQ-028 stage codes and ENV_MAX=16'hFFFF SHALL live in shared package adsr_pkg.
REQ-029 tick prescaler SHALL be a sub-module env_tick (parameter TICK_DIV; ports clk, rst_n, tick).
REQ-030 env_out, stage, busy SHALL be flop outputs, no combinational path from inputs.

Verification (TICK_DIV=1 unless noted)
REQ-031 attack=0x4000, decay=0x1000, sustain=0x8000, gate high -> env 0x4000, 0x8000, 0xC000, 0xFFFF(DECAY), 0xEFFF...0x8000 (stage 3), holds.
REQ-032 in SUSTAIN at 0x8000, release=0x3000, gate low -> 0x5000, 0x2000, 0x0000, stage 0, busy 0.
REQ-033 gate high again during RELEASE at env 0x5000 -> stage 1 next cycle, env continues from 0x5000 up by attack_rate, no drop to 0.
REQ-034 sustain=0xFFFF -> after attack saturates, DECAY -> SUSTAIN on first tick at 0xFFFF; sustain changed to 0x1000 -> env 0x1000 next tick.
REQ-035 TICK_DIV=50, attack=1 -> env increments exactly once per 50 cycles; rst_n pulsed low mid-ATTACK -> env 0, stage 0 without clk edge.
REQ-036 gate pulse of one cycle -> ATTACK one cycle, then RELEASE; attack_rate=0 with gate high -> env frozen, stage stays 1.
